// File: rtl/fetch_stage_if.sv
// fetch_stage_if: single-outstanding instruction-memory request/response bus
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rvalid, rdata);
  modport slave(input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, single-outstanding imem fetch and IF/ID register with hold buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               flushD,
  input  logic               redirect,
  input  logic [31:0]        npc,
  fetch_stage_if.master      imem,
  output logic [31:0]        pcF,
  output logic [31:0]        instrD,
  output logic [31:0]        pcD,
  output logic               validD
);
  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} fetchState;
  fetchState   state;
  logic [31:0] issuedPc;
  logic [31:0] holdInstr;
  logic [31:0] holdPc;
  logic        kill;
  logic        accept;
  logic        loadMem;
  logic        loadHold;
  assign imem.req  = state == ISSUE && !stallF;
  assign imem.addr = pcF;
  assign accept    = imem.req && imem.ready;
  // a redirect in the response cycle makes that word wrong-path as well
  assign loadMem   = state == WAIT && imem.rvalid && !kill && !redirect;
  assign loadHold  = state == HOLD && !redirect;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= ISSUE;
      pcF       <= RESET_PC;
      issuedPc  <= '0;
      kill      <= 1'b0;
      holdInstr <= '0;
      holdPc    <= '0;
      instrD    <= '0;
      pcD       <= '0;
      validD    <= 1'b0;
    end else begin
      pcF <= redirect ? npc : accept ? pcF + 32'd4 : pcF;
      case (state)
        ISSUE: if (accept) begin
          issuedPc <= pcF;
          kill     <= redirect;
          state    <= WAIT;
        end
        WAIT: if (imem.rvalid) begin
          kill <= 1'b0;
          if (loadMem && stallD) begin
            holdInstr <= imem.rdata;
            holdPc    <= issuedPc + 32'd4;
            state     <= HOLD;
          end else state <= ISSUE;
        end else if (redirect) kill <= 1'b1;
        HOLD: if (redirect || flushD || !stallD) state <= ISSUE;
        default: state <= ISSUE;
      endcase
      if (flushD) begin
        instrD <= '0;
        validD <= 1'b0;
      end else if (!stallD) begin
        instrD <= loadMem ? imem.rdata : loadHold ? holdInstr : '0;
        pcD    <= loadMem ? issuedPc + 32'd4 : loadHold ? holdPc : pcD;
        validD <= loadMem || loadHold;
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic against a program-order scoreboard
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } expT;
  logic clk = 0;
  logic rst = 1;
  logic stallF = 0;
  logic stallD = 0;
  logic flushD = 0;
  logic redirect = 0;
  logic [31:0] npc = 0;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  fetch_stage_if mem();
  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .redirect(redirect), .npc(npc), .imem(mem), .pcF(pcF), .instrD(instrD),
    .pcD(pcD), .validD(validD)
  );
  always #5 clk = ~clk;
  expT         expQ[$];
  int          checks = 0;
  int          fails = 0;
  int          readyPct = 100;
  int          latMin = 0;
  int          latMax = 0;
  int          cnt = 0;
  bit          busy = 0;
  bit          acc = 0;
  logic [31:0] pendAddr = 0;
  logic [31:0] lastAcc = 0;
  logic [31:0] expPc = RESET_PC;
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a == 32'h0000_300C ? 32'h2402_0005 : {a[7:0], a[31:8]} ^ 32'hC3C3_0F0F;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  // one cycle of stimulus and memory response; the model advances on accepted fetches
  task automatic drive(input bit sF, input bit sD, input bit fl, input bit rd, input logic [31:0] np);
    stallF = sF;
    stallD = sD;
    flushD = fl;
    redirect = rd;
    npc = np;
    mem.rvalid = busy && cnt == 0;
    mem.rdata = mem.rvalid ? memWord(pendAddr) : $urandom;
    mem.ready = !busy && ($urandom_range(0, 99) < readyPct);
    if (busy) begin
      if (cnt == 0) busy = 0;
      else cnt--;
    end
    #1;
    if (sF && rst) chk("stallF_req", {31'b0, mem.req}, 32'h0);
    acc = rst && mem.req && mem.ready;
    if (acc) begin
      chk("fetch_addr", mem.addr, expPc);
      lastAcc = mem.addr;
      pendAddr = mem.addr;
      busy = 1;
      cnt = $urandom_range(latMin, latMax);
      if (!rd) expQ.push_back('{instr: memWord(expPc), pc: expPc + 32'd4});
      expPc += 32'd4;
    end
    if (rd) begin
      expQ.delete();
      expPc = np;
    end
  endtask
  task automatic cycle(input bit sF, input bit sD, input bit fl, input bit rd, input logic [31:0] np);
    @(negedge clk);
    drive(sF, sD, fl, rd, np);
  endtask
  task automatic waitAcc(input bit anyAddr, input logic [31:0] a);
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0, 0, 32'h0);
      if (acc && (anyAddr || lastAcc == a)) return;
    end
    checks++;
    fails++;
    $display("FAIL wait_accept got=none exp=fetch of %h within 40 cycles", a);
  endtask
  // monitor: IF/ID model follows flush/stall/load/bubble, loads come from the scoreboard
  initial begin
    logic [31:0] mI, mP;
    logic        mV;
    expT         e;
    mI = 0;
    mP = 0;
    mV = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mI = 0;
        mP = 0;
        mV = 0;
      end else if (flushD) begin
        mI = 0;
        mV = 0;
      end else if (!stallD) begin
        if (validD && expQ.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_load got pcD=%h instrD=%h exp=no load", pcD, instrD);
          mI = instrD;
          mP = pcD;
          mV = 1;
        end else if (validD) begin
          e = expQ.pop_front();
          mI = e.instr;
          mP = e.pc;
          mV = 1;
        end else begin
          mI = 0;
          mV = 0;
        end
      end
      chk("ifid_instrD", instrD, mI);
      chk("ifid_pcD", pcD, mP);
      chk("ifid_validD", {31'b0, validD}, {31'b0, mV});
    end
  end
  initial begin
    bit          hit;
    logic [31:0] np;
    int          r;
    mem.ready = 0;
    mem.rvalid = 0;
    mem.rdata = 0;
    #1 rst = 0;
    #2;
    chk("reset_pcF", pcF, RESET_PC);
    chk("reset_addr", mem.addr, RESET_PC);
    chk("reset_instrD", instrD, 32'h0);
    chk("reset_pcD", pcD, 32'h0);
    chk("reset_validD", {31'b0, validD}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1;
    // zero-wait memory: first instruction two cycles after release
    cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #2;
    chk("first_validD", {31'b0, validD}, 32'h1);
    chk("first_pcD", pcD, 32'h0000_3004);
    chk("first_instrD", instrD, memWord(RESET_PC));
    // stall while 0x300C returns, then release
    waitAcc(0, 32'h0000_300C);
    cycle(0, 1, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    chk("hold_req", {31'b0, mem.req}, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    chk("hold_validD", {31'b0, validD}, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #2;
    chk("unhold_instrD", instrD, 32'h2402_0005);
    chk("unhold_pcD", pcD, 32'h0000_3010);
    chk("unhold_validD", {31'b0, validD}, 32'h1);
    // redirect while waiting on a slow response
    latMin = 2;
    latMax = 2;
    waitAcc(1, 32'h0);
    cycle(0, 0, 0, 1, 32'h0000_3040);
    latMin = 0;
    latMax = 0;
    @(posedge clk);
    #2;
    chk("redir_wait_validD", {31'b0, validD}, 32'h0);
    waitAcc(1, 32'h0);
    chk("redir_wait_next", lastAcc, 32'h0000_3040);
    // redirect in the same cycle as the accept at 0x3008
    cycle(0, 0, 0, 1, 32'h0000_3000);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (mem.req && mem.addr == 32'h0000_3008) begin
        drive(0, 0, 0, 1, 32'h0000_3100);
        hit = 1;
      end else drive(0, 0, 0, 0, 32'h0);
    end
    if (!hit) begin
      checks++;
      fails++;
      $display("FAIL same_cycle_redirect got=none exp=request at 00003008");
    end
    @(posedge clk);
    #2;
    chk("redir_accept_pcF", pcF, 32'h0000_3100);
    waitAcc(1, 32'h0);
    chk("redir_accept_next", lastAcc, 32'h0000_3100);
    // flush together with stall while holding
    waitAcc(1, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    cycle(0, 1, 0, 0, 32'h0);
    chk("hold2_req", {31'b0, mem.req}, 32'h0);
    cycle(0, 1, 1, 0, 32'h0);
    if (expQ.size() > 0) void'(expQ.pop_back());
    @(posedge clk);
    #2;
    chk("flush_hold_validD", {31'b0, validD}, 32'h0);
    chk("flush_hold_instrD", instrD, 32'h0);
    cycle(0, 0, 0, 0, 32'h0);
    chk("flush_hold_req", {31'b0, mem.req}, 32'h1);
    // asynchronous reset with a response still outstanding
    latMin = 4;
    latMax = 4;
    waitAcc(1, 32'h0);
    #2 rst = 0;
    #1;
    chk("midreset_pcF", pcF, RESET_PC);
    chk("midreset_instrD", instrD, 32'h0);
    chk("midreset_pcD", pcD, 32'h0);
    chk("midreset_validD", {31'b0, validD}, 32'h0);
    expQ.delete();
    expPc = RESET_PC;
    @(posedge clk);
    #3 rst = 1;
    latMin = 0;
    latMax = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cycle(0, 0, 0, 0, 32'h0);
      if (mem.rvalid) begin
        chk("late_rvalid_req", {31'b0, mem.req}, 32'h1);
        chk("late_rvalid_addr", mem.addr, RESET_PC);
        hit = 1;
      end
    end
    if (!hit) begin
      checks++;
      fails++;
      $display("FAIL late_rvalid got=none exp=response within 10 cycles");
    end
    // random traffic, including wrap-around targets
    readyPct = 70;
    latMax = 3;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      np = r == 0 ? 32'hFFFF_FFF8 : r == 1 ? $urandom : (($urandom & 32'h0000_FFFC) | 32'h0001_0000);
      hit = $urandom_range(0, 99) < 6;
      cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25, hit && $urandom_range(0, 1) == 1, hit, np);
    end
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 32'h0);
    @(posedge clk);
    #3;
    chk("drain_pending", expQ.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
